// File: rtl/pong_frame_controller.sv
// Pong per-frame sequencer: on each vsync rising edge move paddle and ball,
// resolve collisions, then publish every position in the same cycle.
module pong_frame_controller #(
  parameter int GRAPHICS_WIDTH   = 1280,
  parameter int GRAPHICS_HEIGHT  = 800,
  parameter int BORDER_WIDTH     = 50,
  parameter int PADDLE_X         = 110,
  parameter int PADDLE_WIDTH     = 20,
  parameter int PADDLE_LENGTH    = 200,
  parameter int PADDLE_SPEED     = 10,
  parameter int PADDLE_START_Y   = 300,
  parameter int BALL_SIZE        = 16,
  parameter int BALL_SPEED       = 4,
  parameter int POSITION_REG_MAX = 11
) (
  input  logic                    pixel_clock,
  input  logic                    reset_n,
  input  logic                    vga_vertical_sync,
  input  logic                    button_north,
  input  logic                    button_south,
  output logic [POSITION_REG_MAX:0] paddle_y,
  output logic [POSITION_REG_MAX:0] ball_x,
  output logic [POSITION_REG_MAX:0] ball_y,
  output logic [3:0]              miss_count,
  output logic                    update_busy,
  output logic                    frame_done
);

  localparam int XW = POSITION_REG_MAX + 2;

  typedef logic [POSITION_REG_MAX:0] pos_t;
  typedef logic [XW-1:0]             wide_t;
  typedef enum logic [1:0] {
    IDLE, PADDLE, BALL, COLLIDE
  } state_t;

  localparam wide_t BORDER   = wide_t'(BORDER_WIDTH);
  localparam wide_t PAD_SPD  = wide_t'(PADDLE_SPEED);
  localparam wide_t PAD_LEN  = wide_t'(PADDLE_LENGTH);
  localparam wide_t PAD_MAX  =
    wide_t'(GRAPHICS_HEIGHT - BORDER_WIDTH - PADDLE_LENGTH);
  localparam wide_t BALL_SZ  = wide_t'(BALL_SIZE);
  localparam wide_t BALL_SPD = wide_t'(BALL_SPEED);
  localparam wide_t BOTTOM   = wide_t'(GRAPHICS_HEIGHT - BORDER_WIDTH);
  localparam wide_t RIGHT    = wide_t'(GRAPHICS_WIDTH - BORDER_WIDTH);
  localparam wide_t HIT_X    = wide_t'(PADDLE_X + PADDLE_WIDTH);

  localparam pos_t BORDER_P = pos_t'(BORDER_WIDTH);
  localparam pos_t PAD_RST  = pos_t'(PADDLE_START_Y);
  localparam pos_t Y_MAX    =
    pos_t'(GRAPHICS_HEIGHT - BORDER_WIDTH - BALL_SIZE);
  localparam pos_t X_MAX    =
    pos_t'(GRAPHICS_WIDTH - BORDER_WIDTH - BALL_SIZE);
  localparam pos_t X_CTR    = pos_t'(GRAPHICS_WIDTH / 2 - BALL_SIZE / 2);
  localparam pos_t Y_CTR    = pos_t'(GRAPHICS_HEIGHT / 2 - BALL_SIZE / 2);

  state_t state;
  logic   north_s1, north_s2, south_s1, south_s2;
  logic   vsync_q, tick;
  pos_t   pad_r, bx_r, by_r;
  wide_t  nx, ny;
  logic   dir_x, dir_y;
  wide_t  pad_w, bx_w, by_w;
  pos_t   pad_dn, pad_up;
  logic   hit_top, hit_bot, hit_right, on_paddle, hit_pad, missed;
  pos_t   x_next, y_next;
  logic   dx_next, dy_next, miss_inc;

  assign tick  = vga_vertical_sync & ~vsync_q;
  assign pad_w = wide_t'(pad_r);
  assign bx_w  = wide_t'(bx_r);
  assign by_w  = wide_t'(by_r);

  // compare before stepping so the clamp never wraps
  assign pad_dn = (pad_w < BORDER + PAD_SPD) ? BORDER_P
                : pad_r - pos_t'(PADDLE_SPEED);
  assign pad_up = (pad_w + PAD_SPD > PAD_MAX) ? pos_t'(PAD_MAX)
                : pad_r + pos_t'(PADDLE_SPEED);

  assign hit_top   = ny <= BORDER;
  assign hit_bot   = ny + BALL_SZ >= BOTTOM;
  assign hit_right = dir_x && (nx + BALL_SZ >= RIGHT);
  assign on_paddle = (by_w + BALL_SZ > pad_w) &&
                     (by_w < pad_w + PAD_LEN);
  assign hit_pad   = !dir_x && (bx_w >= HIT_X) &&
                     (nx < HIT_X) && on_paddle;
  assign missed    = !dir_x && (nx <= BORDER);

  always_comb begin
    x_next   = pos_t'(nx);
    y_next   = pos_t'(ny);
    dx_next  = dir_x;
    dy_next  = dir_y;
    miss_inc = 1'b0;
    unique case (1'b1)
      hit_top: begin
        y_next  = BORDER_P;
        dy_next = 1'b1;
      end
      hit_bot: begin
        y_next  = Y_MAX;
        dy_next = 1'b0;
      end
      default: ;
    endcase
    priority case (1'b1)
      hit_right: begin
        x_next  = X_MAX;
        dx_next = 1'b0;
      end
      hit_pad: begin
        x_next  = pos_t'(HIT_X);
        dx_next = 1'b1;
      end
      // a miss also discards whatever the y axis resolved to
      missed: begin
        x_next   = X_CTR;
        dx_next  = 1'b1;
        y_next   = Y_CTR;
        dy_next  = dir_y;
        miss_inc = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      north_s1    <= 1'b0;
      north_s2    <= 1'b0;
      south_s1    <= 1'b0;
      south_s2    <= 1'b0;
      vsync_q     <= 1'b1;
      pad_r       <= PAD_RST;
      bx_r        <= X_CTR;
      by_r        <= Y_CTR;
      nx          <= wide_t'(X_CTR);
      ny          <= wide_t'(Y_CTR);
      dir_x       <= 1'b0;
      dir_y       <= 1'b1;
      paddle_y    <= PAD_RST;
      ball_x      <= X_CTR;
      ball_y      <= Y_CTR;
      miss_count  <= 4'd0;
      update_busy <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      north_s1   <= button_north;
      north_s2   <= north_s1;
      south_s1   <= button_south;
      south_s2   <= south_s1;
      vsync_q    <= vga_vertical_sync;
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (tick) begin
            state       <= PADDLE;
            update_busy <= 1'b1;
          end
        end
        PADDLE: begin
          state <= BALL;
          unique case (1'b1)
            north_s2 && !south_s2: pad_r <= pad_dn;
            south_s2 && !north_s2: pad_r <= pad_up;
            default:               pad_r <= pad_r;
          endcase
        end
        BALL: begin
          state <= COLLIDE;
          nx <= dir_x ? bx_w + BALL_SPD
              : (bx_w >= BALL_SPD ? bx_w - BALL_SPD : '0);
          ny <= dir_y ? by_w + BALL_SPD
              : (by_w >= BALL_SPD ? by_w - BALL_SPD : '0);
        end
        COLLIDE: begin
          state       <= IDLE;
          update_busy <= 1'b0;
          frame_done  <= 1'b1;
          bx_r        <= x_next;
          by_r        <= y_next;
          dir_x       <= dx_next;
          dir_y       <= dy_next;
          paddle_y    <= pad_r;
          ball_x      <= x_next;
          ball_y      <= y_next;
          if (miss_inc && miss_count != 4'hf)
            miss_count <= miss_count + 4'd1;
        end
      endcase
    end
  end

endmodule
